// File: rtl/axi4_a23_fetch_burst_if.sv
// AXI4 port bundle (32-bit data, 4-bit ID) with master and slave views.
interface axi4_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic [3:0]  awregion;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic [3:0]  arregion;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_a23_fetch_burst.sv
// Amber A23 fetch/bus unit: single reads/writes and WRAP line fills on one AXI4 master port.
// Define AXI4_A23_FETCH_POSTED_WRITE_EN to complete writes on AW+W and collect B in the background.
module axi4_a23_fetch_burst #(
  parameter int         LINE_WORDS      = 4,
  parameter logic [3:0] AXI_ID          = 4'd0,
  parameter int         CACHEABLE_SHIFT = 27
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [31:0]                   i_address,
  input  logic                          i_address_valid,
  input  logic [31:0]                   i_write_data,
  input  logic                          i_write_enable,
  input  logic [3:0]                    i_byte_enable,
  input  logic                          i_exclusive,
  input  logic                          i_cache_req,
  input  logic                          i_cache_enable,
  input  logic [31:0]                   i_cacheable_area,
  input  logic                          i_system_rdy,
  output logic [31:0]                   o_read_data,
  output logic                          o_read_data_valid,
  output logic [31:0]                   o_fill_data,
  output logic                          o_fill_valid,
  output logic [$clog2(LINE_WORDS)-1:0] o_fill_word_idx,
  output logic                          o_fill_last,
  output logic                          o_fetch_stall,
  output logic                          o_dabt,
  axi4_if.master                        master
);
  localparam int IW = $clog2(LINE_WORDS);

  localparam logic [1:0] R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_AWW = 2'd1, W_B = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01;

  logic [1:0]    r_rstate, r_wstate;
  logic [31:0]   r_addr, r_wdata, r_crit;
  logic [3:0]    r_strb;
  logic          r_rexcl, r_wexcl, r_fill;
  logic          r_aw_done, r_w_done;
  logic [IW-1:0] r_beat_cnt;
  logic          r_over, r_resp_err;

  logic w_is_fill, w_can_rd, w_can_wr, w_start_rd, w_start_wr;
  logic w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
  logic w_ar_hs, w_r_hs, w_rlast_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic w_aw_ok, w_w_ok, w_rd_cmpl, w_wr_cmpl, w_cmpl;
  logic w_r_bad, w_b_bad, w_len_err, w_beat0;

  assign w_is_fill = i_cache_req & i_cache_enable & ~i_write_enable &
                     i_cacheable_area[i_address[CACHEABLE_SHIFT+4:CACHEABLE_SHIFT]];

  assign w_arvalid = (r_rstate == R_AR);
  assign w_rready  = (r_rstate == R_DATA);
  assign w_awvalid = (r_wstate == W_AWW) & ~r_aw_done;
  assign w_wvalid  = (r_wstate == W_AWW) & ~r_w_done;
  assign w_bready  = (r_wstate == W_B);

  assign w_ar_hs    = w_arvalid & master.arready;
  assign w_r_hs     = w_rready & master.rvalid;
  assign w_rlast_hs = w_r_hs & master.rlast;
  assign w_aw_hs    = w_awvalid & master.awready;
  assign w_w_hs     = w_wvalid & master.wready;
  assign w_b_hs     = w_bready & master.bvalid;
  assign w_aw_ok    = r_aw_done | w_aw_hs;
  assign w_w_ok     = r_w_done | w_w_hs;

  assign w_rd_cmpl = w_rlast_hs;
`ifdef AXI4_A23_FETCH_POSTED_WRITE_EN
  // Write is retired to the core once AW and W are both accepted; B drains behind later reads.
  assign w_wr_cmpl = (r_wstate == W_AWW) & w_aw_ok & w_w_ok;
  assign w_can_rd  = (r_rstate == R_IDLE) & (r_wstate != W_AWW);
`else
  assign w_wr_cmpl = w_b_hs;
  assign w_can_rd  = (r_rstate == R_IDLE) & (r_wstate == W_IDLE);
`endif
  assign w_can_wr = (r_rstate == R_IDLE) & (r_wstate == W_IDLE);
  assign w_cmpl   = w_rd_cmpl | w_wr_cmpl;

  assign w_start_rd = i_address_valid & ~i_write_enable & w_can_rd & ~w_cmpl;
  assign w_start_wr = i_address_valid & i_write_enable & w_can_wr & ~w_cmpl;

  assign w_r_bad = r_rexcl ? (master.rresp != RESP_EXOKAY) : (master.rresp != RESP_OKAY);
  assign w_b_bad = r_wexcl ? (master.bresp != RESP_EXOKAY) : (master.bresp != RESP_OKAY);
  // RLAST must land exactly on beat LINE_WORDS-1; r_over flags a burst that ran past it.
  assign w_len_err = r_fill & (r_over | (r_beat_cnt != IW'(LINE_WORDS - 1)));
  assign w_beat0   = (r_beat_cnt == '0) & ~r_over;

  assign o_fetch_stall     = ~i_system_rdy | (i_address_valid & ~w_cmpl);
  assign o_read_data_valid = w_rd_cmpl;
  assign o_read_data       = (r_fill & ~w_beat0) ? r_crit : master.rdata;
  assign o_dabt            = (w_rd_cmpl & (r_resp_err | w_r_bad | w_len_err)) | (w_b_hs & w_b_bad);
  assign o_fill_valid      = r_fill & w_r_hs & ~r_over;
  assign o_fill_data       = master.rdata;
  assign o_fill_word_idx   = r_addr[IW+1:2] + r_beat_cnt;
  assign o_fill_last       = o_fill_valid & master.rlast;

  assign master.arid     = AXI_ID;
  assign master.araddr   = r_fill ? {r_addr[31:2], 2'b00} : r_addr;
  assign master.arlen    = r_fill ? 8'(LINE_WORDS - 1) : 8'd0;
  assign master.arsize   = 3'd2;
  assign master.arburst  = r_fill ? 2'b10 : 2'b01;
  assign master.arlock   = r_rexcl;
  assign master.arcache  = 4'd0;
  assign master.arprot   = 3'd0;
  assign master.arqos    = 4'd0;
  assign master.arregion = 4'd0;
  assign master.arvalid  = w_arvalid;
  assign master.rready   = w_rready;
  assign master.awid     = AXI_ID;
  assign master.awaddr   = r_addr;
  assign master.awlen    = 8'd0;
  assign master.awsize   = 3'd2;
  assign master.awburst  = 2'b01;
  assign master.awlock   = r_wexcl;
  assign master.awcache  = 4'd0;
  assign master.awprot   = 3'd0;
  assign master.awqos    = 4'd0;
  assign master.awregion = 4'd0;
  assign master.awvalid  = w_awvalid;
  assign master.wdata    = r_wdata;
  assign master.wstrb    = r_strb;
  assign master.wlast    = 1'b1;
  assign master.wvalid   = w_wvalid;
  assign master.bready   = w_bready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_rstate   <= R_IDLE;
      r_wstate   <= W_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_strb     <= '0;
      r_crit     <= '0;
      r_rexcl    <= 1'b0;
      r_wexcl    <= 1'b0;
      r_fill     <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_beat_cnt <= '0;
      r_over     <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_start_rd | w_start_wr) r_addr <= i_address;

      case (r_rstate)
        R_IDLE: if (w_start_rd) begin
          r_rstate   <= R_AR;
          r_fill     <= w_is_fill;
          r_rexcl    <= i_exclusive;
          r_beat_cnt <= '0;
          r_over     <= 1'b0;
          r_resp_err <= 1'b0;
        end
        R_AR: if (w_ar_hs) r_rstate <= R_DATA;
        R_DATA: if (w_r_hs) begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
          if (r_beat_cnt == IW'(LINE_WORDS - 1)) r_over <= 1'b1;
          if (w_r_bad) r_resp_err <= 1'b1;
          if (w_beat0) r_crit <= master.rdata;
          if (master.rlast) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase

      case (r_wstate)
        W_IDLE: if (w_start_wr) begin
          r_wstate  <= W_AWW;
          r_wdata   <= i_write_data;
          r_strb    <= i_byte_enable;
          r_wexcl   <= i_exclusive;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        W_AWW: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs) r_w_done <= 1'b1;
          if (w_aw_ok & w_w_ok) r_wstate <= W_B;
        end
        W_B: if (w_b_hs) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end
endmodule

// File: doc/axi4_a23_fetch_burst.md
Name: axi4_a23_fetch_burst

Overview:
- Next-generation AXI4 fetch/bus-interface unit for the Amber A23 core.
- Adds parametrised cache-line fill using WRAP bursts with critical word first, a fill-data stream to the cache, and a latched request address.
- AW and W are issued concurrently, and AXI ID and line size are parametrised.
- Sits between the A23 core/cache and one AXI4 master port.

Parameters:
- LINE_WORDS, 4, words per cache line fill; legal values 2, 4, 8, 16 (AXI WRAP lengths).
- AXI_ID, 0, constant driven on ARID/AWID.
- CACHEABLE_SHIFT, 27, low bit of the address slice indexing i_cacheable_area (bits [CACHEABLE_SHIFT+4:CACHEABLE_SHIFT]).

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_address  in  32  core byte address
- i_address_valid  in  1  core request present
- i_write_data  in  32  store data
- i_write_enable  in  1  1 = write, 0 = read
- i_byte_enable  in  4  store strobes
- i_exclusive  in  1  exclusive (swap) access; drives ARLOCK/AWLOCK
- i_cache_req  in  1  read is a line fill (ignored for writes)
- i_cache_enable  in  1  line fills allowed
- i_cacheable_area  in  32  per-region cacheable bits
- i_system_rdy  in  1  system ready
- o_read_data  out  32  read data to core
- o_read_data_valid  out  1  read data qualifier (1 cycle)
- o_fill_data  out  32  line-fill beat data
- o_fill_valid  out  1  fill beat valid
- o_fill_word_idx  out  $clog2(LINE_WORDS)  word index of the current fill beat
- o_fill_last  out  1  final fill beat
- o_fetch_stall  out  1  hold pipeline
- o_dabt  out  1  bus error (1 cycle)
- master  interface  axi4_if.master  AXI4 master port

Behaviour:
- Reset (i_rstn=0 at posedge): both FSMs go idle; all VALID/READY low; o_read_data_valid, o_fill_valid, o_fill_last, o_dabt = 0.
  - Reset mid-burst abandons the transfer; the interconnect is reset together with this block.
- Request capture: in IDLE, with i_address_valid=1 and no completion this cycle, latch address, data, strobes, exclusive and fill mode.
  - Latched values drive the AXI address and data fields for the whole transaction.
- is_fill = i_cache_req & i_cache_enable & !i_write_enable & i_cacheable_area[addr slice].
- Read FSM:
  - R_IDLE -> R_AR on a read request.
  - R_AR: ARVALID=1.
    - Single read: ARLEN=0, ARBURST=INCR, ARADDR = latched address.
    - Fill: ARLEN=LINE_WORDS-1, ARBURST=WRAP, ARADDR = {addr[31:2],2'b00}.
    - ARSIZE=2 in both cases. On ARREADY -> R_DATA.
  - R_DATA: RREADY=1; each R handshake counts a beat; RLAST handshake -> R_IDLE.
- Fill beats:
  - o_fill_valid=1 on each R handshake; o_fill_data=RDATA.
  - o_fill_word_idx = (start_idx + beat_cnt) mod LINE_WORDS, where start_idx = addr[$clog2(LINE_WORDS)+1:2].
  - o_fill_last on the RLAST beat.
  - Beat 0 (critical word) is registered and presented on o_read_data at completion.
- Write FSM:
  - W_IDLE -> W_AWW on a write request.
  - W_AWW: AWVALID and WVALID are asserted together; AWLEN=0, AWSIZE=2, WLAST=1, WSTRB = latched strobes.
  - Each VALID drops independently after its own handshake (aw_done/w_done flags). Both done -> W_B.
  - W_B: BREADY=1; B handshake -> W_IDLE.
- Completion cycle:
  - Read: RLAST handshake.
  - Write: B handshake.
  - In the completion cycle o_fetch_stall falls and o_read_data_valid=1 for reads. o_read_data = RDATA for singles, the registered critical word for fills.
- o_fetch_stall = !i_system_rdy | (i_address_valid & !completion).
  - Next request is accepted no earlier than the cycle after completion.
- Error checks (o_dabt pulses in the completion cycle):
  - Non-exclusive: RESP != OKAY on any beat (sticky across the burst).
  - Exclusive: RESP != EXOKAY.
  - Fill: RLAST count mismatch, i.e. early RLAST or missing RLAST at beat LINE_WORDS.
- Tie-offs: ARCACHE/AWCACHE/ARPROT/AWPROT/QOS/REGION = 0; ARID/AWID = AXI_ID.
- Concurrency: read and write FSMs are never active together, except the write-buffer case under the optional feature.

Optional Feature:
- Macro: AXI4_A23_FETCH_POSTED_WRITE_EN.
- Enabled:
  - A write completes to the core when both AW and W handshakes are done; B is awaited in the background.
  - BRESP error raises o_dabt in the cycle B is accepted (imprecise).
  - A new read may start while in W_B.
  - A new write stalls until W_B clears.
- Disabled: behaviour as above; the write completes on B only.

Test Plan:
- Single read 0x0000_1004, ARREADY after 2 cycles, RDATA=0xDEADBEEF RLAST -> ARLEN=0 INCR; o_read_data_valid 1 cycle with 0xDEADBEEF; stall drops that cycle.
- Write 0x200 data 0x12345678 strobe 0xF, AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds 3; completes on B OKAY; o_dabt=0.
- Fill LINE_WORDS=4 at 0x108 with cache_req/enable/cacheable set -> ARADDR=0x108, ARLEN=3, WRAP; fill idx 2,3,0,1; o_fill_last on beat 4; o_read_data = beat 0 data.
- Exclusive read with RRESP=OKAY -> o_dabt=1; same with EXOKAY -> o_dabt=0; ARLOCK=1 throughout.
- Fill with RLAST on beat 2 -> o_dabt=1 at that beat; FSM back to idle.
- Reset asserted mid-fill beat 2 -> next cycle ARVALID/RREADY=0, o_fill_valid=0; new read after reset starts cleanly.
